sprite_draw_scheduler: RTL and testbench

- Sequences all VGA plotting for the game's sprites (player, enemies, bullet).
- Takes each sprite's `move` pulse and current box (x, y, width, colour), arbitrates round-robin among pending sprites, erases the sprite's last-drawn box, then draws the new one.
- Emits one pixel per cycle to the single VGA adapter plot port.
- Also performs a full-screen clear on level load.

---
 rtl/sprite_draw_scheduler.sv | 242 ++++++++++++++++++++++++
 tb/tb_sprite_draw_scheduler.sv | 384 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_draw_scheduler.sv
// Round-robin sprite erase/redraw and full-screen clear onto one VGA plot port; DRAW_SKIP_STATIC_EN drops unchanged redraws.
// Latency: first pixel the cycle after ARB, one pixel per cycle, a service costs 1 + last_w^2 + new_w^2 cycles.
// No backpressure: repeated req_move pulses merge into one pending bit, busy reports any non-IDLE state.
module sprite_draw_scheduler #(
    parameter int         NUM_SPRITES = 4,
    parameter int         SCREEN_W    = 160,
    parameter int         SCREEN_H    = 120,
    parameter logic [2:0] BG_COLOUR   = 3'b000
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic [NUM_SPRITES-1:0]   req_move,
    input  logic [8*NUM_SPRITES-1:0] sprite_x,
    input  logic [7*NUM_SPRITES-1:0] sprite_y,
    input  logic [3*NUM_SPRITES-1:0] sprite_w,
    input  logic [3*NUM_SPRITES-1:0] sprite_colour,
    input  logic                     clear_all,
    output logic                     busy,
    output logic                     plot,
    output logic [7:0]               vga_x,
    output logic [6:0]               vga_y,
    output logic [2:0]               vga_colour
);
    localparam int         IW     = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;
    localparam logic [7:0] X_LAST = 8'(SCREEN_W - 1);
    localparam logic [6:0] Y_LAST = 7'(SCREEN_H - 1);

    typedef enum logic [2:0] {IDLE, ARB, ERASE, DRAW, CLEAR} state_t;

    state_t                 state;
    logic [NUM_SPRITES-1:0] pending, pending_nxt;
    logic [IW-1:0]          rr_ptr, grant, cur;
    logic                   found;
    int                     idx;
    logic [7:0]             last_x [NUM_SPRITES];
    logic [6:0]             last_y [NUM_SPRITES];
    logic [2:0]             last_w [NUM_SPRITES];
`ifdef DRAW_SKIP_STATIC_EN
    logic [2:0]             last_c [NUM_SPRITES];
    logic                   arb_static;
`endif
    logic [7:0]             new_x, scan_bx, off_x;
    logic [6:0]             new_y, scan_by, off_y;
    logic [2:0]             new_w, new_c, scan_w;
    logic [7:0]             g_x;
    logic [6:0]             g_y;
    logic [2:0]             g_w, g_c;
    logic                   box_row_end, box_last, clr_row_end, clr_last;
    logic [7:0]             box_nx, clr_nx;
    logic [6:0]             box_ny, clr_ny;
    logic [8:0]             box_px;
    logic [7:0]             box_py;

    function automatic logic on_screen(input logic [8:0] px, input logic [7:0] py);
        return (int'(px) < SCREEN_W) && (int'(py) < SCREEN_H);
    endfunction

    assign busy = (state != IDLE);

    // First pending requester at or after the round-robin pointer.
    always_comb begin
        grant = rr_ptr;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < NUM_SPRITES; k++) begin
            idx = (int'(rr_ptr) + k) % NUM_SPRITES;
            if (!found && pending[idx]) begin
                grant = IW'(idx);
                found = 1'b1;
            end
        end
    end

    assign g_x = sprite_x[8*int'(grant) +: 8];
    assign g_y = sprite_y[7*int'(grant) +: 7];
    assign g_w = sprite_w[3*int'(grant) +: 3];
    assign g_c = sprite_colour[3*int'(grant) +: 3];
`ifdef DRAW_SKIP_STATIC_EN
    assign arb_static = (g_x == last_x[grant]) && (g_y == last_y[grant]) &&
                        (g_w == last_w[grant]) && (g_c == last_c[grant]);
`endif

    // Offsets hold the pixel currently on the outputs; these give the next one.
    assign box_row_end = (off_x == {5'b0, scan_w} - 8'd1);
    assign box_last    = box_row_end && (off_y == {4'b0, scan_w} - 7'd1);
    assign box_nx      = box_row_end ? 8'd0 : off_x + 8'd1;
    assign box_ny      = box_row_end ? off_y + 7'd1 : off_y;
    assign box_px      = {1'b0, scan_bx} + {1'b0, box_nx};
    assign box_py      = {1'b0, scan_by} + {1'b0, box_ny};
    assign clr_row_end = (off_x == X_LAST);
    assign clr_last    = clr_row_end && (off_y == Y_LAST);
    assign clr_nx      = clr_row_end ? 8'd0 : off_x + 8'd1;
    assign clr_ny      = clr_row_end ? off_y + 7'd1 : off_y;

    always_comb begin
        pending_nxt = pending;
        if (state == ARB) pending_nxt[grant] = 1'b0;
        if (state != CLEAR) pending_nxt = pending_nxt | req_move;
        if (clear_all) pending_nxt = '0;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            pending    <= '0;
            rr_ptr     <= '0;
            cur        <= '0;
            for (int i = 0; i < NUM_SPRITES; i++) begin
                last_x[i] <= '0;
                last_y[i] <= '0;
                last_w[i] <= '0;
`ifdef DRAW_SKIP_STATIC_EN
                last_c[i] <= '0;
`endif
            end
            new_x      <= '0;
            new_y      <= '0;
            new_w      <= '0;
            new_c      <= '0;
            scan_bx    <= '0;
            scan_by    <= '0;
            scan_w     <= '0;
            off_x      <= '0;
            off_y      <= '0;
            plot       <= 1'b0;
            vga_x      <= '0;
            vga_y      <= '0;
            vga_colour <= '0;
        end else begin
            pending <= pending_nxt;
            if (clear_all) begin
                state      <= CLEAR;
                off_x      <= '0;
                off_y      <= '0;
                plot       <= 1'b1;
                vga_x      <= '0;
                vga_y      <= '0;
                vga_colour <= BG_COLOUR;
                for (int i = 0; i < NUM_SPRITES; i++) last_w[i] <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        plot <= 1'b0;
                        if (|pending) state <= ARB;
                    end
                    ARB: begin
                        rr_ptr <= (grant == IW'(NUM_SPRITES - 1)) ? '0 : grant + 1'b1;
                        cur    <= grant;
                        new_x  <= g_x;
                        new_y  <= g_y;
                        new_w  <= g_w;
                        new_c  <= g_c;
                        off_x  <= '0;
                        off_y  <= '0;
`ifdef DRAW_SKIP_STATIC_EN
                        if (arb_static) begin
                            state <= IDLE;
                            plot  <= 1'b0;
                        end else
`endif
                        if (last_w[grant] != 3'd0) begin
                            state      <= ERASE;
                            scan_bx    <= last_x[grant];
                            scan_by    <= last_y[grant];
                            scan_w     <= last_w[grant];
                            vga_x      <= last_x[grant];
                            vga_y      <= last_y[grant];
                            vga_colour <= BG_COLOUR;
                            plot       <= on_screen({1'b0, last_x[grant]}, {1'b0, last_y[grant]});
                        end else if (g_w != 3'd0) begin
                            state      <= DRAW;
                            scan_bx    <= g_x;
                            scan_by    <= g_y;
                            scan_w     <= g_w;
                            vga_x      <= g_x;
                            vga_y      <= g_y;
                            vga_colour <= g_c;
                            plot       <= on_screen({1'b0, g_x}, {1'b0, g_y});
                        end else begin
                            state <= IDLE;
                            plot  <= 1'b0;
                        end
                    end
                    ERASE: begin
                        if (!box_last) begin
                            off_x <= box_nx;
                            off_y <= box_ny;
                            vga_x <= box_px[7:0];
                            vga_y <= box_py[6:0];
                            plot  <= on_screen(box_px, box_py);
                        end else if (new_w != 3'd0) begin
                            state      <= DRAW;
                            scan_bx    <= new_x;
                            scan_by    <= new_y;
                            scan_w     <= new_w;
                            off_x      <= '0;
                            off_y      <= '0;
                            vga_x      <= new_x;
                            vga_y      <= new_y;
                            vga_colour <= new_c;
                            plot       <= on_screen({1'b0, new_x}, {1'b0, new_y});
                        end else begin
                            last_w[cur] <= '0;
                            state       <= IDLE;
                            plot        <= 1'b0;
                        end
                    end
                    DRAW: begin
                        if (!box_last) begin
                            off_x <= box_nx;
                            off_y <= box_ny;
                            vga_x <= box_px[7:0];
                            vga_y <= box_py[6:0];
                            plot  <= on_screen(box_px, box_py);
                        end else begin
                            last_x[cur] <= new_x;
                            last_y[cur] <= new_y;
                            last_w[cur] <= new_w;
`ifdef DRAW_SKIP_STATIC_EN
                            last_c[cur] <= new_c;
`endif
                            state       <= IDLE;
                            plot        <= 1'b0;
                        end
                    end
                    CLEAR: begin
                        if (!clr_last) begin
                            off_x <= clr_nx;
                            off_y <= clr_ny;
                            vga_x <= clr_nx;
                            vga_y <= clr_ny;
                        end else begin
                            state <= IDLE;
                            plot  <= 1'b0;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_sprite_draw_scheduler.sv
// Self-checking bench for sprite_draw_scheduler: directed scenarios plus randomized multi-sprite requests
// compared against a box-list reference model of erase/draw order and pixel streams.
module tb_sprite_draw_scheduler;
    localparam int N = 4;

    logic          clk = 1'b0;
    logic          resetn = 1'b1;
    logic [N-1:0]  req_move = '0;
    logic [8*N-1:0] sprite_x = '0;
    logic [7*N-1:0] sprite_y = '0;
    logic [3*N-1:0] sprite_w = '0;
    logic [3*N-1:0] sprite_colour = '0;
    logic          clear_all = 1'b0;
    logic          busy, plot;
    logic [7:0]    vga_x;
    logic [6:0]    vga_y;
    logic [2:0]    vga_colour;

    sprite_draw_scheduler #(.NUM_SPRITES(N), .SCREEN_W(160), .SCREEN_H(120), .BG_COLOUR(3'b000)) dut (
        .clk(clk), .resetn(resetn), .req_move(req_move), .sprite_x(sprite_x), .sprite_y(sprite_y),
        .sprite_w(sprite_w), .sprite_colour(sprite_colour), .clear_all(clear_all), .busy(busy),
        .plot(plot), .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour));

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state: what each sprite last left on screen, and the round-robin start.
    int bx[N], by[N], bw[N], bc[N];
    int m_lx[N], m_ly[N], m_lw[N], m_lc[N];
    int m_rr = 0;

    // Busy-cycle samples from the DUT and the expected stream from the model.
    logic b_plot[$];
    int   b_x[$], b_y[$], b_c[$];
    bit   e_plot[$];
    int   e_x[$], e_y[$], e_c[$];

    task automatic apply_sprites();
        for (int i = 0; i < N; i++) begin
            sprite_x[8*i +: 8]      = 8'(bx[i]);
            sprite_y[7*i +: 7]      = 7'(by[i]);
            sprite_w[3*i +: 3]      = 3'(bw[i]);
            sprite_colour[3*i +: 3] = 3'(bc[i]);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_lx[i] = 0; m_ly[i] = 0; m_lw[i] = 0; m_lc[i] = 0;
        end
        m_rr = 0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1 resetn = 1'b0;
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
        model_reset();
    endtask

    task automatic rr_order(input logic [N-1:0] mask, output int q[$]);
        int p;
        logic [N-1:0] m;
        p = m_rr;
        m = mask;
        q = {};
        while (m != '0) begin
            for (int k = 0; k < N; k++) begin
                int i;
                i = (p + k) % N;
                if (m[i]) begin
                    q.push_back(i);
                    m[i] = 1'b0;
                    p = (i + 1) % N;
                    break;
                end
            end
        end
    endtask

    task automatic push_box(input int x0, input int y0, input int w, input int c);
        for (int k = 0; k < w * w; k++) begin
            int x, y;
            x = x0 + k % w;
            y = y0 + k / w;
            e_plot.push_back(x < 160 && y < 120);
            e_x.push_back(x); e_y.push_back(y); e_c.push_back(c);
        end
    endtask

    // Expected busy-cycle stream for a sequence of services: ARB, erase old box, draw new box.
    task automatic build_expected(input int ids[$]);
        e_plot.delete(); e_x.delete(); e_y.delete(); e_c.delete();
        foreach (ids[n]) begin
            int s;
            bit skip;
            s = ids[n];
            skip = 1'b0;
`ifdef DRAW_SKIP_STATIC_EN
            skip = (bx[s] == m_lx[s]) && (by[s] == m_ly[s]) && (bw[s] == m_lw[s]) && (bc[s] == m_lc[s]);
`endif
            e_plot.push_back(1'b0); e_x.push_back(0); e_y.push_back(0); e_c.push_back(0);
            if (!skip) begin
                push_box(m_lx[s], m_ly[s], m_lw[s], 0);
                push_box(bx[s], by[s], bw[s], bc[s]);
                if (bw[s] == 0) m_lw[s] = 0;
                else begin
                    m_lx[s] = bx[s]; m_ly[s] = by[s]; m_lw[s] = bw[s]; m_lc[s] = bc[s];
                end
            end
            m_rr = (s + 1) % N;
        end
    endtask

    task automatic collect(input logic [N-1:0] m0, input int c2, input logic [N-1:0] m2, output bit timed_out);
        int idle_run;
        bit seen;
        idle_run = 0;
        seen = 1'b0;
        timed_out = 1'b1;
        b_plot.delete(); b_x.delete(); b_y.delete(); b_c.delete();
        for (int i = 0; i < 4000; i++) begin
            @(posedge clk); #1;
            req_move = (i == 0) ? m0 : ((i == c2) ? m2 : '0);
            @(negedge clk);
            if (busy === 1'b1) begin
                seen = 1'b1;
                idle_run = 0;
                b_plot.push_back(plot); b_x.push_back(int'(vga_x));
                b_y.push_back(int'(vga_y)); b_c.push_back(int'(vga_colour));
            end else idle_run++;
            if (seen && idle_run >= 3) begin
                timed_out = 1'b0;
                break;
            end
        end
        req_move = '0;
    endtask

    function automatic int count_bad();
        int bad;
        bad = 0;
        for (int j = 0; j < b_plot.size() && j < e_plot.size(); j++)
            if (b_plot[j] !== e_plot[j] ||
                (e_plot[j] && (b_x[j] != e_x[j] || b_y[j] != e_y[j] || b_c[j] != e_c[j]))) bad++;
        return bad;
    endfunction

    function automatic int count_plots();
        int n;
        n = 0;
        foreach (b_plot[j]) if (b_plot[j] === 1'b1) n++;
        return n;
    endfunction

    task automatic test_reset();
        #2 resetn = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || plot !== 1'b0) begin
            errors++; $display("FAIL reset_ctrl: busy=%b plot=%b, want 0 0", busy, plot);
        end
        checks++;
        if (vga_x !== 8'd0 || vga_y !== 7'd0 || vga_colour !== 3'd0) begin
            errors++; $display("FAIL reset_pix: x=%0d y=%0d c=%0d, want 0 0 0", vga_x, vga_y, vga_colour);
        end
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
        model_reset();
    endtask

    task automatic test_first_draw();
        bit to;
        int q[$];
        bx[0] = 80; by[0] = 115; bw[0] = 3; bc[0] = 7;
        apply_sprites();
        q = {0};
        build_expected(q);
        collect(4'b0001, -1, '0, to);
        checks++;
        if (to) begin errors++; $display("FAIL first_draw_timeout: busy never settled, want idle"); end
        checks++;
        if (b_plot.size() != 10) begin
            errors++; $display("FAIL first_draw_len: busy cycles %0d, want 10", b_plot.size());
        end
        checks++;
        if (count_bad() != 0 || count_plots() != 9) begin
            errors++; $display("FAIL first_draw_pix: %0d bad cycles %0d plots, want 0 bad 9 plots", count_bad(), count_plots());
        end
    endtask

    task automatic test_erase_redraw();
        bit to;
        int q[$];
        bx[0] = 79;
        apply_sprites();
        q = {0};
        build_expected(q);
        collect(4'b0001, -1, '0, to);
        checks++;
        if (to || b_plot.size() != 19) begin
            errors++; $display("FAIL move_len: busy cycles %0d timeout %0b, want 19 0", b_plot.size(), to);
        end
        checks++;
        if (count_bad() != 0) begin
            errors++; $display("FAIL move_pix: %0d bad cycles, want 0", count_bad());
        end
    endtask

    task automatic test_round_robin();
        bit to;
        int q[$];
        do_reset();
        bx[1] = 10; by[1] = 10; bw[1] = 2; bc[1] = 3;
        bx[2] = 30; by[2] = 20; bw[2] = 2; bc[2] = 5;
        apply_sprites();
        rr_order(4'b0110, q);
        q.push_back(1);
        build_expected(q);
        // Cycle 10 falls inside sprite 2's draw, so sprite 1 must be serviced a second time.
        collect(4'b0110, 10, 4'b0010, to);
        checks++;
        if (to || b_plot.size() != e_plot.size()) begin
            errors++; $display("FAIL rr_len: busy cycles %0d timeout %0b, want %0d 0", b_plot.size(), to, e_plot.size());
        end
        checks++;
        if (count_bad() != 0) begin
            errors++; $display("FAIL rr_pix: %0d bad cycles, want 0", count_bad());
        end
    endtask

    task automatic test_clip();
        bit to;
        int q[$];
        bx[3] = 158; by[3] = 118; bw[3] = 3; bc[3] = 2;
        apply_sprites();
        q = {3};
        build_expected(q);
        collect(4'b1000, -1, '0, to);
        checks++;
        if (to || b_plot.size() != 10 || count_plots() != 4) begin
            errors++; $display("FAIL clip_count: busy %0d plots %0d, want 10 4", b_plot.size(), count_plots());
        end
        checks++;
        if (count_bad() != 0) begin
            errors++; $display("FAIL clip_pix: %0d bad cycles, want 0", count_bad());
        end
    endtask

    task automatic test_clear();
        int bad;
        bit to;
        int q[$];
        do_reset();
        bx[0] = 20; by[0] = 20; bw[0] = 7; bc[0] = 6;
        bx[2] = 50; by[2] = 50; bw[2] = 2; bc[2] = 4;
        apply_sprites();
        for (int i = 0; i <= 10; i++) begin
            @(posedge clk); #1;
            req_move = (i == 0) ? 4'b0001 : ((i == 5) ? 4'b0100 : 4'b0000);
            clear_all = (i == 10);
            @(negedge clk);
        end
        checks++;
        if (busy !== 1'b1 || plot !== 1'b1 || vga_colour !== 3'd6) begin
            errors++; $display("FAIL clear_predraw: busy=%b plot=%b c=%0d, want 1 1 6", busy, plot, vga_colour);
        end
        bad = 0;
        for (int k = 0; k < 19200; k++) begin
            @(posedge clk); #1 clear_all = 1'b0;
            @(negedge clk);
            if (k == 0) begin
                checks++;
                if (plot !== 1'b1 || vga_x !== 8'd0 || vga_y !== 7'd0 || vga_colour !== 3'd0) begin
                    errors++; $display("FAIL clear_first: plot=%b x=%0d y=%0d c=%0d, want 1 0 0 0", plot, vga_x, vga_y, vga_colour);
                end
            end
            if (plot !== 1'b1 || busy !== 1'b1 || int'(vga_x) != k % 160 || int'(vga_y) != k / 160 || vga_colour !== 3'd0) bad++;
        end
        checks++;
        if (bad != 0 || vga_x !== 8'd159 || vga_y !== 7'd119) begin
            errors++; $display("FAIL clear_raster: %0d bad pixels last (%0d,%0d), want 0 bad last (159,119)", bad, vga_x, vga_y);
        end
        bad = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (busy !== 1'b0 || plot !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL clear_drops_pending: %0d busy cycles after clear, want 0", bad);
        end
        // Sprite 0 was granted before the clear; the clear leaves nothing on screen to erase.
        for (int i = 0; i < N; i++) m_lw[i] = 0;
        m_rr = 1;
        q = {0};
        build_expected(q);
        collect(4'b0001, -1, '0, to);
        checks++;
        if (to || b_plot.size() != 50 || count_bad() != 0) begin
            errors++; $display("FAIL clear_then_draw: busy %0d bad %0d, want 50 0", b_plot.size(), count_bad());
        end
    endtask

    task automatic test_reset_mid_erase();
        int bad;
        bx[0] = 21;
        apply_sprites();
        for (int i = 0; i <= 6; i++) begin
            @(posedge clk); #1;
            req_move = (i == 0) ? 4'b0001 : 4'b0000;
            @(negedge clk);
        end
        checks++;
        if (plot !== 1'b1 || vga_colour !== 3'd0 || busy !== 1'b1) begin
            errors++; $display("FAIL pre_reset_erase: plot=%b c=%0d busy=%b, want 1 0 1", plot, vga_colour, busy);
        end
        #2 resetn = 1'b0;
        #1;
        checks++;
        if (plot !== 1'b0 || busy !== 1'b0 || vga_x !== 8'd0 || vga_y !== 7'd0 || vga_colour !== 3'd0) begin
            errors++; $display("FAIL async_reset: plot=%b busy=%b x=%0d y=%0d c=%0d, want all 0", plot, busy, vga_x, vga_y, vga_colour);
        end
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
        model_reset();
        bad = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (plot !== 1'b0 || busy !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL post_reset_quiet: %0d active cycles, want 0", bad);
        end
    endtask

    task automatic test_random();
        bit to;
        int q[$];
        logic [N-1:0] m;
        for (int it = 0; it < 30; it++) begin
            m = N'($urandom_range(1, (1 << N) - 1));
            for (int i = 0; i < N; i++) begin
                if (m[i] && $urandom_range(0, 4) != 0) begin
                    bx[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(150, 255) : $urandom_range(0, 159);
                    by[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(110, 127) : $urandom_range(0, 119);
                    bw[i] = $urandom_range(0, 7);
                    bc[i] = $urandom_range(0, 7);
                end
            end
            apply_sprites();
            rr_order(m, q);
            build_expected(q);
            collect(m, -1, '0, to);
            checks++;
            if (to || b_plot.size() != e_plot.size()) begin
                errors++; $display("FAIL rand_len it%0d: busy %0d timeout %0b, want %0d 0", it, b_plot.size(), to, e_plot.size());
            end
            checks++;
            if (count_bad() != 0) begin
                errors++; $display("FAIL rand_pix it%0d: %0d bad cycles, want 0", it, count_bad());
            end
        end
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            bx[i] = 0; by[i] = 0; bw[i] = 0; bc[i] = 0;
        end
        test_reset();
        test_first_draw();
        test_erase_redraw();
        test_round_robin();
        test_clip();
        test_clear();
        test_reset_mid_erase();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
